// File: rtl/bicubic_phase_gen.sv
// Bicubic resampler phase generator: walks a Q12.8 source position per output pixel/line.
// Optional macro PHASE_CENTER_ALIGN_EN starts each axis at (step/2 - 128), floored at 0.
module bicubic_phase_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] cfg_step_x,
  input  logic [15:0] cfg_step_y,
  input  logic [11:0] cfg_dst_w,
  input  logic [11:0] cfg_dst_h,
  input  logic [11:0] cfg_src_w,
  input  logic [8:0]  cfg_bi_a,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [11:0] x_int,
  output logic [8:0]  x_blend,
  output logic [11:0] y_int,
  output logic [8:0]  y_blend,
  output logic [8:0]  coeff_one,
  output logic [8:0]  coeff_half,
  output logic [8:0]  bi_a,
  output logic        sol,
  output logic        eol,
  output logic        eof,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [15:0] step_x_r, step_y_r;
  logic [11:0] dst_w_r, dst_h_r, src_w_r;
  logic [19:0] x_acc, y_acc;
  logic [11:0] col, line;

  logic [19:0] init_x_new, init_y_new, init_x_reload;
  logic [19:0] nxt_x, nxt_y;
  logic [11:0] nxt_col, nxt_line;
  logic [20:0] x_map_start, x_map_run;

  assign coeff_one  = 9'd256;
  assign coeff_half = 9'd128;

`ifdef PHASE_CENTER_ALIGN_EN
  function automatic logic [19:0] center_init(input logic [15:0] step);
    logic [14:0] half;
    half = step[15:1];
    center_init = (half >= 15'd128) ? {5'd0, half - 15'd128} : '0;
  endfunction

  assign init_x_new    = center_init(cfg_step_x);
  assign init_y_new    = center_init(cfg_step_y);
  assign init_x_reload = center_init(step_x_r);
`else
  assign init_x_new    = '0;
  assign init_y_new    = '0;
  assign init_x_reload = '0;
`endif

  // Returns {x_int, x_blend}; positions past the source edge pin to the last column.
  function automatic logic [20:0] map_x(input logic [19:0] acc, input logic [11:0] lim);
    if (acc[19:8] > lim) map_x = {lim, 9'd0};
    else                 map_x = {acc[19:8], 1'b0, acc[7:0]};
  endfunction

  always_comb begin
    nxt_x    = x_acc;
    nxt_y    = y_acc;
    nxt_col  = col;
    nxt_line = line;
    if (col == dst_w_r) begin
      nxt_x    = init_x_reload;
      nxt_y    = y_acc + {4'd0, step_y_r};
      nxt_col  = '0;
      nxt_line = line + 12'd1;
    end else begin
      nxt_x   = x_acc + {4'd0, step_x_r};
      nxt_col = col + 12'd1;
    end
  end

  assign x_map_start = map_x(init_x_new, cfg_src_w);
  assign x_map_run   = map_x(nxt_x, src_w_r);

  // Output fields are registered from the next-beat values so they change only on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step_x_r  <= '0;
      step_y_r  <= '0;
      dst_w_r   <= '0;
      dst_h_r   <= '0;
      src_w_r   <= '0;
      x_acc     <= '0;
      y_acc     <= '0;
      col       <= '0;
      line      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      x_int     <= '0;
      x_blend   <= '0;
      y_int     <= '0;
      y_blend   <= '0;
      bi_a      <= '0;
      sol       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            step_x_r           <= cfg_step_x;
            step_y_r           <= cfg_step_y;
            dst_w_r            <= cfg_dst_w;
            dst_h_r            <= cfg_dst_h;
            src_w_r            <= cfg_src_w;
            bi_a               <= cfg_bi_a;
            x_acc              <= init_x_new;
            y_acc              <= init_y_new;
            col                <= '0;
            line               <= '0;
            {x_int, x_blend}   <= x_map_start;
            y_int              <= init_y_new[19:8];
            y_blend            <= {1'b0, init_y_new[7:0]};
            sol                <= 1'b1;
            eol                <= (cfg_dst_w == '0);
            eof                <= (cfg_dst_w == '0) && (cfg_dst_h == '0);
            out_valid          <= 1'b1;
            busy               <= 1'b1;
            state              <= RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            if (eof) begin
              out_valid <= 1'b0;
              sol       <= 1'b0;
              eol       <= 1'b0;
              eof       <= 1'b0;
              state     <= DONE;
            end else begin
              x_acc            <= nxt_x;
              y_acc            <= nxt_y;
              col              <= nxt_col;
              line             <= nxt_line;
              {x_int, x_blend} <= x_map_run;
              y_int            <= nxt_y[19:8];
              y_blend          <= {1'b0, nxt_y[7:0]};
              sol              <= (nxt_col == '0);
              eol              <= (nxt_col == dst_w_r);
              eof              <= (nxt_col == dst_w_r) && (nxt_line == dst_h_r);
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bicubic_phase_gen.sv
// Self-checking bench for bicubic_phase_gen: directed table, stall/reset sequences and
// randomized frames checked against a closed-form position model.
module tb_bicubic_phase_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_step_x = '0, cfg_step_y = '0;
  logic [11:0] cfg_dst_w = '0, cfg_dst_h = '0, cfg_src_w = '0;
  logic [8:0]  cfg_bi_a = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [11:0] x_int, y_int;
  logic [8:0]  x_blend, y_blend, coeff_one, coeff_half, bi_a;
  logic        sol, eol, eof, busy;

  bicubic_phase_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_step_x(cfg_step_x), .cfg_step_y(cfg_step_y),
    .cfg_dst_w(cfg_dst_w), .cfg_dst_h(cfg_dst_h), .cfg_src_w(cfg_src_w),
    .cfg_bi_a(cfg_bi_a), .out_ready(out_ready), .out_valid(out_valid),
    .x_int(x_int), .x_blend(x_blend), .y_int(y_int), .y_blend(y_blend),
    .coeff_one(coeff_one), .coeff_half(coeff_half), .bi_a(bi_a),
    .sol(sol), .eol(eol), .eof(eof), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] sx;
    logic [15:0] sy;
    logic [11:0] w;
    logic [11:0] h;
    logic [11:0] src;
    logic [8:0]  a;
  } cfg_t;

  typedef struct packed {
    logic        v;
    logic [11:0] xi;
    logic [8:0]  xb;
    logic [11:0] yi;
    logic [8:0]  yb;
    logic        sol;
    logic        eol;
    logic        eof;
    logic [8:0]  ba;
    logic [8:0]  c1;
    logic [8:0]  c2;
  } beat_t;

  typedef struct {
    cfg_t  cfg;
    int    beat;
    beat_t exp;
  } vec_t;

  int    vectors = 0;
  int    miscompares = 0;
  vec_t  tbl[$];
  beat_t cap[$];

  function automatic beat_t dut_beat();
    beat_t b;
    b.v = out_valid; b.xi = x_int; b.xb = x_blend; b.yi = y_int; b.yb = y_blend;
    b.sol = sol; b.eol = eol; b.eof = eof; b.ba = bi_a; b.c1 = coeff_one; b.c2 = coeff_half;
    return b;
  endfunction

  function automatic longint init_of(input logic [15:0] step);
`ifdef PHASE_CENTER_ALIGN_EN
    longint h;
    h = longint'(step) / 2;
    return (h >= 128) ? h - 128 : 0;
`else
    return (step == step) ? 0 : 0;
`endif
  endfunction

  // Beat n of a frame: position = init + index*step, wrapped to 20 bits, x pinned at src edge.
  function automatic beat_t model(input cfg_t c, input int n);
    beat_t  b;
    longint cl, ln, xa, ya, wid;
    wid = longint'(c.w) + 1;
    cl = longint'(n) % wid;
    ln = longint'(n) / wid;
    xa = (init_of(c.sx) + cl * longint'(c.sx)) % (64'd1 << 20);
    ya = (init_of(c.sy) + ln * longint'(c.sy)) % (64'd1 << 20);
    b.v = 1'b1;
    if ((xa / 256) > longint'(c.src)) begin
      b.xi = c.src; b.xb = 9'd0;
    end else begin
      b.xi = 12'(xa / 256); b.xb = 9'(xa % 256);
    end
    b.yi = 12'(ya / 256); b.yb = 9'(ya % 256);
    b.sol = (cl == 0);
    b.eol = (cl == longint'(c.w));
    b.eof = b.eol && (ln == longint'(c.h));
    b.ba = c.a; b.c1 = 9'd256; b.c2 = 9'd128;
    return b;
  endfunction

  task automatic check_beat(input string name, input beat_t act, input beat_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got v=%0b xi=%0d xb=%0d yi=%0d yb=%0d sol/eol/eof=%0b%0b%0b bi_a=%0d c=%0d/%0d, want v=%0b xi=%0d xb=%0d yi=%0d yb=%0d sol/eol/eof=%0b%0b%0b bi_a=%0d c=%0d/%0d",
               name, act.v, act.xi, act.xb, act.yi, act.yb, act.sol, act.eol, act.eof, act.ba, act.c1, act.c2,
               exp.v, exp.xi, exp.xb, exp.yi, exp.yb, exp.sol, exp.eol, exp.eof, exp.ba, exp.c1, exp.c2);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic drive_cfg(input cfg_t c);
    cfg_step_x = c.sx; cfg_step_y = c.sy; cfg_dst_w = c.w; cfg_dst_h = c.h;
    cfg_src_w = c.src; cfg_bi_a = c.a;
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.sx = 16'($urandom); c.sy = 16'($urandom); c.w = 12'($urandom_range(0, 20));
    c.h = 12'($urandom_range(0, 4)); c.src = 12'($urandom); c.a = 9'($urandom);
    return c;
  endfunction

  // Runs one frame from IDLE; cfg inputs and start are scrambled while the frame is active.
  task automatic run_frame(input cfg_t c, input bit rnd_ready, input int stall_beat, input int stall_len);
    int    total, n, cyc, scnt;
    bit    rdy, stalled;
    beat_t cur, snap;
    total = (int'(c.w) + 1) * (int'(c.h) + 1);
    cap.delete();
    drive_cfg(c);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_bit("busy_on_start", busy, 1'b1);
    n = 0; cyc = 0; scnt = 0; stalled = 1'b0; snap = '0;
    while (n < total && cyc < total * 8 + 50) begin
      cur = dut_beat();
      if (stalled) check_beat("stall_hold", cur, snap);
      drive_cfg(rand_cfg());
      start = 1'($urandom_range(0, 1));
      if (rnd_ready) rdy = ($urandom_range(0, 3) != 0);
      else if (n == stall_beat && scnt < stall_len) begin rdy = 1'b0; scnt++; end
      else rdy = 1'b1;
      out_ready = rdy;
      if (rdy) begin
        check_beat($sformatf("beat%0d", n), cur, model(c, n));
        cap.push_back(cur);
      end else snap = cur;
      stalled = !rdy;
      @(posedge clk); #1;
      cyc++;
      if (rdy) n++;
    end
    if (n < total) begin
      vectors++; miscompares++;
      $display("FAIL frame_timeout: got %0d beats want %0d", n, total);
    end
    start = 1'b1;
    check_bit("valid_after_eof", out_valid, 1'b0);
    check_bit("busy_in_done", busy, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    check_bit("busy_idle", busy, 1'b0);
    check_bit("valid_idle", out_valid, 1'b0);
  endtask

  function automatic void add(input cfg_t c, input int beat, input logic [11:0] xi, input logic [8:0] xb,
                              input logic [11:0] yi, input logic [8:0] yb,
                              input logic s, input logic e, input logic f);
    vec_t t;
    t.cfg = c; t.beat = beat;
    t.exp.v = 1'b1; t.exp.xi = xi; t.exp.xb = xb; t.exp.yi = yi; t.exp.yb = yb;
    t.exp.sol = s; t.exp.eol = e; t.exp.eof = f; t.exp.ba = c.a;
    t.exp.c1 = 9'd256; t.exp.c2 = 9'd128;
    tbl.push_back(t);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cfg_t  c19, c20, c22, c24, c11, cs, cr;
    beat_t rst_exp;
    c19 = '{sx: 16'h0100, sy: 16'h0000, w: 12'd3, h: 12'd0, src: 12'd15, a: 9'h055};
    c20 = '{sx: 16'h0080, sy: 16'h0080, w: 12'd3, h: 12'd1, src: 12'd15, a: 9'h0AA};
    c22 = '{sx: 16'h0300, sy: 16'h0000, w: 12'd7, h: 12'd0, src: 12'd9,  a: 9'h100};
    c24 = '{sx: 16'h0200, sy: 16'h0000, w: 12'd2, h: 12'd0, src: 12'd15, a: 9'h001};
    c11 = '{sx: 16'h0100, sy: 16'h0100, w: 12'd0, h: 12'd0, src: 12'd15, a: 9'h0FF};

    for (int i = 0; i < 4; i++)
      add(c19, i, 12'(i), 9'd0, 12'd0, 9'd0, i == 0, i == 3, i == 3);
    for (int l = 0; l < 2; l++) begin
      add(c20, 4*l + 0, 12'd0, 9'd0,   12'd0, l ? 9'd128 : 9'd0, 1'b1, 1'b0, 1'b0);
      add(c20, 4*l + 1, 12'd0, 9'd128, 12'd0, l ? 9'd128 : 9'd0, 1'b0, 1'b0, 1'b0);
      add(c20, 4*l + 2, 12'd1, 9'd0,   12'd0, l ? 9'd128 : 9'd0, 1'b0, 1'b0, 1'b0);
      add(c20, 4*l + 3, 12'd1, 9'd128, 12'd0, l ? 9'd128 : 9'd0, 1'b0, 1'b1, l == 1);
    end
`ifdef PHASE_CENTER_ALIGN_EN
    add(c22, 0, 12'd1, 9'd0, 12'd0, 9'd0, 1'b1, 1'b0, 1'b0);
    add(c22, 1, 12'd4, 9'd0, 12'd0, 9'd0, 1'b0, 1'b0, 1'b0);
    add(c22, 2, 12'd7, 9'd0, 12'd0, 9'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 3; i < 8; i++)
      add(c22, i, 12'd9, 9'd0, 12'd0, 9'd0, 1'b0, i == 7, i == 7);
    for (int i = 0; i < 3; i++)
      add(c24, i, 12'(2*i), 9'd128, 12'd0, 9'd0, i == 0, i == 2, i == 2);
`else
    for (int i = 0; i < 8; i++)
      add(c22, i, (i < 4) ? 12'(3*i) : 12'd9, 9'd0, 12'd0, 9'd0, i == 0, i == 7, i == 7);
    for (int i = 0; i < 3; i++)
      add(c24, i, 12'(2*i), 9'd0, 12'd0, 9'd0, i == 0, i == 2, i == 2);
`endif
    add(c11, 0, 12'd0, 9'd0, 12'd0, 9'd0, 1'b1, 1'b1, 1'b1);

    rst_exp = '0;
    rst_exp.c1 = 9'd256;
    rst_exp.c2 = 9'd128;

    #1;
    check_beat("reset_state", dut_beat(), rst_exp);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_beat("idle_after_reset", dut_beat(), rst_exp);

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 0 || tbl[i].cfg != tbl[i-1].cfg) run_frame(tbl[i].cfg, 1'b0, -1, 0);
      if (tbl[i].beat < cap.size()) check_beat($sformatf("tbl%0d", i), cap[tbl[i].beat], tbl[i].exp);
      else begin
        vectors++; miscompares++;
        $display("FAIL tbl%0d: got %0d beats want beat %0d", i, cap.size(), tbl[i].beat);
      end
    end

    // Long stall on beat 2; stability and sequence are checked inside run_frame.
    cs = '{sx: 16'h0140, sy: 16'h0233, w: 12'd5, h: 12'd1, src: 12'd40, a: 9'h033};
    run_frame(cs, 1'b0, 2, 5);

    // Reset in the middle of line 1, then a fresh frame.
    cr = '{sx: 16'h0180, sy: 16'h0100, w: 12'd7, h: 12'd2, src: 12'd100, a: 9'h077};
    drive_cfg(cr);
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check_beat("pre_reset_beat13", dut_beat(), model(cr, 13));
    rst_n = 1'b0;
    #1;
    check_beat("mid_frame_reset", dut_beat(), rst_exp);
    check_bit("busy_in_reset", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_bit("valid_in_reset", out_valid, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(cr, 1'b0, -1, 0);
    if (cap.size() > 0) begin
      check_bit("restart_sol", cap[0].sol, 1'b1);
      check_bit("restart_x0", cap[0].xi == 12'd0, 1'b1);
      check_bit("restart_y0", cap[0].yi == 12'd0, 1'b1);
    end

    for (int f = 0; f < 10; f++) run_frame(rand_cfg(), 1'b1, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
